// File: rtl/game_sequencer_pkg.sv
// frogger_pkg: shared state encoding and field widths for the frogger game blocks
package frogger_pkg;
  localparam int LEVEL_W = 4;
  localparam int LIVES_W = 2;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    LEVEL_UP  = 3'd3,
    GAME_OVER = 3'd4,
    VICTORY   = 3'd5
  } state_t;
endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: tick/start/collision inputs and level/lives/round-control outputs of the game sequencer
interface game_sequencer_if;
  import frogger_pkg::*;
  logic tick;
  logic start;
  logic death_collision;
  logic win_collision;
  logic [LEVEL_W-1:0] current_level;
  logic [LIVES_W-1:0] lives;
  logic round_reset;
  logic freeze;
  logic flash;
  logic game_over;
  logic victory;
  logic [2:0] state_dbg;
  modport master (
    input  tick, start, death_collision, win_collision,
    output current_level, lives, round_reset, freeze, flash, game_over, victory, state_dbg
  );
  modport slave (
    output tick, start, death_collision, win_collision,
    input  current_level, lives, round_reset, freeze, flash, game_over, victory, state_dbg
  );
endinterface

// File: rtl/game_sequencer_tick_timer.sv
// tick_timer: loadable down-counter stepped by tick; done fires on the tick seen at zero
module tick_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         done
);
  assign done = (count == '0) & tick;
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (load) count <= value;
    else if (tick && count != '0) count <= count - 1'b1;
  end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: frogger round sequencer owning level/lives, pause timing, freeze/flash and round reset
module game_sequencer
  import frogger_pkg::*;
#(
  parameter int START_LIVES = 3,
  parameter int MAX_LEVEL   = 8,
  parameter int DEATH_TICKS = 100,
  parameter int WIN_TICKS   = 50,
  parameter int FLASH_TICKS = 10
) (
  input  logic              clk,
  input  logic              reset,
  game_sequencer_if.master  bus
);
  localparam int TMAX = DEATH_TICKS > WIN_TICKS ? DEATH_TICKS : WIN_TICKS;
  localparam int TW   = TMAX > 0 ? $clog2(TMAX + 1) : 1;
  localparam int FT   = FLASH_TICKS > 0 ? FLASH_TICKS : 1;
  localparam int FW   = $clog2(FT + 1);
  state_t state;
  logic start_q;
  logic start_rise;
  logic armed;
  logic t_load;
  logic t_done;
  logic [TW-1:0] t_value;
  logic [TW-1:0] t_count;
  logic [FW-1:0] f_cnt;
  assign start_rise    = bus.start & ~start_q;
  assign armed         = (state == PLAY) & ~bus.round_reset;
  assign t_load        = armed & (bus.death_collision | bus.win_collision);
  assign t_value       = bus.death_collision ? TW'(DEATH_TICKS) : TW'(WIN_TICKS);
  assign bus.state_dbg = state;
  tick_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (bus.tick),
    .load  (t_load),
    .value (t_value),
    .count (t_count),
    .done  (t_done)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      bus.current_level <= LEVEL_W'(1);
      bus.lives         <= LIVES_W'(START_LIVES);
      bus.round_reset   <= 1'b0;
      bus.freeze        <= 1'b1;
      bus.flash         <= 1'b0;
      bus.game_over     <= 1'b0;
      bus.victory       <= 1'b0;
      start_q           <= 1'b0;
      f_cnt             <= '0;
    end else begin
      start_q         <= bus.start;
      bus.round_reset <= 1'b0;
      case (state)
        IDLE, GAME_OVER, VICTORY: begin
          if (start_rise) begin
            state             <= PLAY;
            bus.current_level <= LEVEL_W'(1);
            bus.lives         <= LIVES_W'(START_LIVES);
            bus.round_reset   <= 1'b1;
            bus.freeze        <= 1'b0;
            bus.game_over     <= 1'b0;
            bus.victory       <= 1'b0;
          end
        end
        PLAY: begin
          if (armed && bus.death_collision) begin
            state      <= DYING;
            bus.lives  <= bus.lives - 1'b1;
            bus.freeze <= 1'b1;
            bus.flash  <= 1'b1;
            f_cnt      <= '0;
          end else if (armed && bus.win_collision) begin
            state      <= LEVEL_UP;
            bus.freeze <= 1'b1;
          end
        end
        DYING: begin
          if (t_done) begin
            bus.flash <= 1'b0;
            if (bus.lives == '0) begin
              state         <= GAME_OVER;
              bus.game_over <= 1'b1;
            end else begin
              state           <= PLAY;
              bus.round_reset <= 1'b1;
              bus.freeze      <= 1'b0;
            end
          end else if (bus.tick) begin
            if (f_cnt == FW'(FT - 1)) begin
              f_cnt <= '0;
              if (t_count != TW'(1)) bus.flash <= ~bus.flash;
            end else begin
              f_cnt <= f_cnt + 1'b1;
            end
          end
        end
        LEVEL_UP: begin
          if (t_done) begin
            if (bus.current_level == LEVEL_W'(MAX_LEVEL)) begin
              state       <= VICTORY;
              bus.victory <= 1'b1;
            end else begin
              state             <= PLAY;
              bus.current_level <= bus.current_level + 1'b1;
              bus.round_reset   <= 1'b1;
              bus.freeze        <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scoreboard bench for game_sequencer
module tb_game_sequencer;
  import frogger_pkg::*;
  typedef struct {
    int level;
    int lives;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];
  game_sequencer_if bus();
  game_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.round_reset === 1'b1) begin
      chk("rr_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rr_level", int'(bus.current_level), e.level);
        chk("rr_lives", int'(bus.lives), e.lives);
      end
    end
  endtask
  task automatic push(input int level, input int lives);
    exp_t e;
    e.level = level;
    e.lives = lives;
    exp_q.push_back(e);
  endtask
  task automatic run_pause(input state_t st, output int ticks, output int toggles);
    logic prev;
    ticks = 0;
    toggles = 0;
    for (int i = 0; i < 400; i++) begin
      prev = bus.flash;
      bus.tick = 1'b1;
      step();
      ticks++;
      if (bus.state_dbg == st && bus.flash != prev) toggles++;
      bus.tick = 1'b0;
      step();
      if (bus.state_dbg != st) break;
    end
  endtask
  task automatic chk_state(input string tag, input state_t st, input int level, input int lives);
    chk({tag, "_state"}, int'(bus.state_dbg), int'(st));
    chk({tag, "_level"}, int'(bus.current_level), level);
    chk({tag, "_lives"}, int'(bus.lives), lives);
  endtask
  initial begin
    int ticks, toggles;
    bus.tick = 1'b0;
    bus.start = 1'b0;
    bus.death_collision = 1'b0;
    bus.win_collision = 1'b0;
    step();
    step();
    chk_state("reset", IDLE, 1, 3);
    chk("reset_freeze", int'(bus.freeze), 1);
    chk("reset_flash", int'(bus.flash), 0);
    chk("reset_game_over", int'(bus.game_over), 0);
    chk("reset_victory", int'(bus.victory), 0);
    chk("reset_rr", int'(bus.round_reset), 0);
    reset = 1'b0;
    step();
    push(1, 3);
    bus.start = 1'b1;
    step();
    step();
    step();
    bus.start = 1'b0;
    chk_state("start", PLAY, 1, 3);
    chk("start_freeze", int'(bus.freeze), 0);
    chk("start_one_pulse", exp_q.size(), 0);
    bus.death_collision = 1'b1;
    step();
    bus.death_collision = 1'b0;
    chk_state("death1", DYING, 1, 2);
    chk("death1_flash", int'(bus.flash), 1);
    chk("death1_freeze", int'(bus.freeze), 1);
    push(1, 2);
    run_pause(DYING, ticks, toggles);
    chk("death1_ticks", ticks, 101);
    chk("death1_toggles", toggles, 9);
    chk_state("death1_exit", PLAY, 1, 2);
    chk("death1_exit_flash", int'(bus.flash), 0);
    chk("death1_exit_freeze", int'(bus.freeze), 0);
    bus.death_collision = 1'b1;
    step();
    bus.death_collision = 1'b0;
    chk_state("death2", DYING, 1, 1);
    push(1, 1);
    run_pause(DYING, ticks, toggles);
    chk_state("death2_exit", PLAY, 1, 1);
    bus.death_collision = 1'b1;
    step();
    bus.death_collision = 1'b0;
    chk_state("death3", DYING, 1, 0);
    run_pause(DYING, ticks, toggles);
    chk_state("gameover", GAME_OVER, 1, 0);
    chk("gameover_flag", int'(bus.game_over), 1);
    chk("gameover_freeze", int'(bus.freeze), 1);
    push(1, 3);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_state("restart", PLAY, 1, 3);
    chk("restart_game_over", int'(bus.game_over), 0);
    step();
    bus.death_collision = 1'b1;
    bus.win_collision = 1'b1;
    step();
    bus.death_collision = 1'b0;
    bus.win_collision = 1'b0;
    chk_state("both", DYING, 1, 2);
    push(1, 2);
    run_pause(DYING, ticks, toggles);
    chk_state("both_exit", PLAY, 1, 2);
    for (int lvl = 1; lvl <= 8; lvl++) begin
      bus.win_collision = 1'b1;
      step();
      bus.win_collision = 1'b0;
      chk_state("win", LEVEL_UP, lvl, 2);
      if (lvl < 8) push(lvl + 1, 2);
      run_pause(LEVEL_UP, ticks, toggles);
      chk("win_ticks", ticks, 51);
      if (lvl < 8) chk_state("win_exit", PLAY, lvl + 1, 2);
    end
    chk_state("victory", VICTORY, 8, 2);
    chk("victory_flag", int'(bus.victory), 1);
    chk("victory_no_pulse", exp_q.size(), 0);
    push(1, 3);
    bus.start = 1'b1;
    bus.death_collision = 1'b1;
    step();
    chk_state("hold_rr", PLAY, 1, 3);
    step();
    chk_state("hold_ignored", PLAY, 1, 3);
    step();
    bus.death_collision = 1'b0;
    bus.start = 1'b0;
    chk_state("hold_dying", DYING, 1, 2);
    push(1, 2);
    run_pause(DYING, ticks, toggles);
    bus.win_collision = 1'b1;
    step();
    bus.win_collision = 1'b0;
    push(2, 2);
    run_pause(LEVEL_UP, ticks, toggles);
    chk_state("lvl2", PLAY, 2, 2);
    bus.win_collision = 1'b1;
    step();
    bus.win_collision = 1'b0;
    chk_state("abort_lvlup", LEVEL_UP, 2, 2);
    for (int i = 0; i < 5; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_state("abort", IDLE, 1, 3);
    chk("abort_rr", int'(bus.round_reset), 0);
    chk("abort_freeze", int'(bus.freeze), 1);
    step();
    chk("abort_idle_hold", int'(bus.state_dbg), int'(IDLE));
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
